// File: rtl/dmem.sv
// ---------------------------------------------------------------------------
// dmem -- word-organised data memory for the CPU memory stage
//
// Byte-addressed, word-aligned storage of DEPTH words of WIDTH bits.
// Writes happen on the rising clock edge; reads are purely combinational,
// so a word written on an edge is visible on RD right after that edge.
// Reset is asynchronous and active-low and clears every word immediately.
//
// Optional feature (macro DMEM_BOUNDS_CHECK_EN):
//   When defined, addresses with nonzero bits above the word index are
//   out of range: writes to them are dropped, reads return 0, and an
//   extra ERR output flags out-of-range or misaligned addresses.
//   When undefined, upper address bits are ignored (addresses alias
//   modulo 4*DEPTH) and misaligned addresses are silently aligned.
//
// Parameters:
//   WIDTH  data and address bus width in bits
//   DEPTH  number of words, power of two
//
// Ports:
//   CLK    clock, writes on rising edge
//   RST_N  asynchronous active-low reset, clears all contents
//   WE     write enable, active high
//   A      byte address, bits [1:0] ignored
//   WD     write data
//   ERR    (DMEM_BOUNDS_CHECK_EN only) out-of-range or misaligned address
//   RD     combinational read data for the word at A
// ---------------------------------------------------------------------------
module dmem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             WE,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] WD,
`ifdef DMEM_BOUNDS_CHECK_EN
  output logic             ERR,
`endif
  output logic [WIDTH-1:0] RD
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int HI_LSB = IDX_W + 2;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0] idx;
  logic             addr_known;
  logic             wr_ok;

  assign idx = A[IDX_W+1:2];

  // A write with an unknown address must not touch any word, so the
  // address is qualified as fully known before the write is allowed.
  assign addr_known = !$isunknown(A);

`ifdef DMEM_BOUNDS_CHECK_EN
  logic out_of_range;

  assign out_of_range = |(A >> HI_LSB);

  // Comparing WE against 1'b1 makes an X or Z enable evaluate as no-write.
  assign wr_ok = (WE == 1'b1) && addr_known && !out_of_range;

  assign RD  = out_of_range ? '0 : mem[idx];

  // ERR is forced low during reset so it never flags stale addresses.
  assign ERR = RST_N && (out_of_range || (A[1:0] != 2'b00));
`else
  assign wr_ok = (WE == 1'b1) && addr_known;

  assign RD = mem[idx];
`endif

  // Reset clears every word asynchronously; reads during reset therefore
  // return 0 without needing a clock edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[idx] <= WD;
    end
  end

endmodule

// File: tb/tb_dmem.sv
// ---------------------------------------------------------------------------
// tb_dmem -- self-checking bench for dmem (WIDTH=48, DEPTH=64)
//
// Checks reset clearing, fill/readback, write-enable gating, combinational
// read with same-word write, asynchronous reset mid-operation, and address
// aliasing or bounds checking depending on DMEM_BOUNDS_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_dmem;

  localparam int W = 48;
  localparam int D = 64;

  logic         CLK;
  logic         RST_N;
  logic         WE;
  logic [W-1:0] A;
  logic [W-1:0] WD;
  logic [W-1:0] RD;
`ifdef DMEM_BOUNDS_CHECK_EN
  logic         ERR;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    string        name;
    logic         we;
    logic [W-1:0] a;
    logic [W-1:0] wd;
    logic [W-1:0] exp_before;
    logic [W-1:0] exp_after;
    logic         exp_err;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  dmem #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .WE    (WE),
    .A     (A),
    .WD    (WD),
`ifdef DMEM_BOUNDS_CHECK_EN
    .ERR   (ERR),
`endif
    .RD    (RD)
  );

  // 10 ns clock period
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string name, input logic [W-1:0] act,
                             input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkErr(input string name, input logic exp);
`ifdef DMEM_BOUNDS_CHECK_EN
    total++;
    if (ERR !== exp) begin
      bad++;
      $display("[TB] FAIL %s ERR: got %b expected %b", name, ERR, exp);
    end
`endif
  endtask

  // Drive one vector at the falling edge, check the combinational read
  // before the rising edge, then check again just after it.
  task automatic applyStimulus(input vec_t v);
    @(negedge CLK);
    WE = v.we;
    A  = v.a;
    WD = v.wd;
    #1;
    checkOutput({v.name, " before"}, RD, v.exp_before);
    checkErr({v.name, " before"}, v.exp_err);
    @(posedge CLK);
    #1;
    checkOutput({v.name, " after"}, RD, v.exp_after);
    checkErr({v.name, " after"}, v.exp_err);
  endtask

  function automatic vec_t mk(input string n, input logic we,
                              input logic [W-1:0] a, input logic [W-1:0] wd,
                              input logic [W-1:0] eb, input logic [W-1:0] ea,
                              input logic er);
    vec_t v;
    v.name = n; v.we = we; v.a = a; v.wd = wd;
    v.exp_before = eb; v.exp_after = ea; v.exp_err = er;
    return v;
  endfunction

  initial begin
    // Table applied after the fill, where word k holds 4*k (k<=62).
    vecs[0]  = mk("rd16",      1'b0, 48'd16, 48'd0, 48'd16, 48'd16, 1'b0);
    vecs[1]  = mk("wr16_5",    1'b1, 48'd16, 48'd5, 48'd16, 48'd5,  1'b0);
    vecs[2]  = mk("wr16_9",    1'b1, 48'd16, 48'd9, 48'd5,  48'd9,  1'b0);
    vecs[3]  = mk("rd20",      1'b0, 48'd20, 48'd0, 48'd20, 48'd20, 1'b0);
    vecs[4]  = mk("rd18_mis",  1'b0, 48'd18, 48'd0, 48'd9,  48'd9,  1'b1);
    vecs[5]  = mk("wr23_mis",  1'b1, 48'd23, 48'hABCDEF012345,
                  48'd20, 48'hABCDEF012345, 1'b1);
    vecs[6]  = mk("rd20b",     1'b0, 48'd20, 48'd0,
                  48'hABCDEF012345, 48'hABCDEF012345, 1'b0);
    vecs[7]  = mk("wr252",     1'b1, 48'd252, 48'hFFFFFFFFFFFF,
                  48'd0, 48'hFFFFFFFFFFFF, 1'b0);
    vecs[8]  = mk("wr0",       1'b1, 48'd0, 48'd1, 48'd0, 48'd1, 1'b0);
    vecs[9]  = mk("wr4_7",     1'b1, 48'd4, 48'd7, 48'd4, 48'd7, 1'b0);
`ifdef DMEM_BOUNDS_CHECK_EN
    vecs[10] = mk("rd260",     1'b0, 48'd260, 48'd0, 48'd0, 48'd0, 1'b1);
    vecs[11] = mk("rd6",       1'b0, 48'd6, 48'd0, 48'd7, 48'd7, 1'b1);
    vecs[12] = mk("wr260",     1'b1, 48'd260, 48'd3, 48'd0, 48'd0, 1'b1);
    vecs[13] = mk("rd4",       1'b0, 48'd4, 48'd0, 48'd7, 48'd7, 1'b0);
`else
    vecs[10] = mk("rd260",     1'b0, 48'd260, 48'd0, 48'd7, 48'd7, 1'b1);
    vecs[11] = mk("rd6",       1'b0, 48'd6, 48'd0, 48'd7, 48'd7, 1'b1);
    vecs[12] = mk("wr260",     1'b1, 48'd260, 48'd3, 48'd7, 48'd3, 1'b1);
    vecs[13] = mk("rd4",       1'b0, 48'd4, 48'd0, 48'd3, 48'd3, 1'b0);
`endif

    // Reset then read
    RST_N = 1'b0;
    WE    = 1'b0;
    A     = '0;
    WD    = '0;
    #3;
    checkOutput("rst_rd0", RD, 48'd0);
    checkErr("rst_err", 1'b0);
    A = 48'd6;
    #1;
    checkErr("rst_err_mis", 1'b0);
    #16;
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 4 * D; i += 4) begin
      A = W'(i);
      #1;
      checkOutput($sformatf("post_rst_a%0d", i), RD, 48'd0);
    end

    // Write-enable gating on a freshly reset memory
    @(negedge CLK);
    WE = 1'bx;
    A  = 48'd8;
    WD = 48'hABC;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      checkOutput("we_x_gate", RD, 48'd0);
    end
    @(negedge CLK);
    WE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      checkOutput("we_0_gate", RD, 48'd0);
    end

    // Fill on consecutive edges, one write per cycle
    for (int i = 0; i <= 248; i += 4) begin
      @(negedge CLK);
      WE = 1'b1;
      A  = W'(i);
      WD = W'(i);
    end
    @(negedge CLK);
    WE = 1'b0;
    for (int i = 0; i < 4 * D; i += 4) begin
      A = W'(i);
      #1;
      checkOutput($sformatf("fill_a%0d", i), RD, (i <= 248) ? W'(i) : 48'd0);
    end

    // Table-driven vectors
    for (int k = 0; k < NVEC; k++) begin
      applyStimulus(vecs[k]);
    end

    // Asynchronous reset between edges, with a blocked write during reset
    @(negedge CLK);
    WE = 1'b0;
    A  = 48'd40;
    #1;
    checkOutput("pre_async_rd40", RD, 48'd40);
    #1;
    RST_N = 1'b0;
    #1;
    checkOutput("async_rd40", RD, 48'd0);
    A = 48'd248;
    #1;
    checkOutput("async_rd248", RD, 48'd0);
    WE = 1'b1;
    A  = 48'd40;
    WD = 48'd55;
    @(posedge CLK);
    #1;
    checkOutput("rst_blocks_wr", RD, 48'd0);
    @(negedge CLK);
    WE    = 1'b0;
    RST_N = 1'b1;
    #1;
    checkOutput("post_async_rd40", RD, 48'd0);
    @(posedge CLK);
    #1;
    checkOutput("post_async_edge", RD, 48'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
